// File: rtl/fpu_regfile_sb.sv
// FPU register file: two write ports (y wins), two read ports, per-register scoreboard.
// Optional same-cycle write/clear forwarding on the read ports: FPU_REGFILE_BYPASS_EN.
module fpu_regfile_sb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic          busy_a,
  output logic          busy_b,
  input  logic [AW-1:0] wnx,
  input  logic [AW-1:0] wny,
  input  logic [DW-1:0] dx,
  input  logic [DW-1:0] dy,
  input  logic          wex,
  input  logic          wey,
  input  logic          iss,
  input  logic [AW-1:0] iss_rn,
  output logic [AW:0]   pend_cnt,
  output logic          idle,
  output logic          sb_err
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0]   rf [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic            clear_x;
  logic            clear_y;
  logic            set_new;
  logic            err_hit;
  logic            same_clr;
  logic [AW:0]     n_clr;
  logic [AW:0]     cnt_nxt;

  always_comb begin
    clear_x  = wex & pend[wnx];
    clear_y  = wey & pend[wny];
    clr_vec  = '0;
    set_vec  = '0;
    if (clear_x) clr_vec[wnx] = 1'b1;
    if (clear_y) clr_vec[wny] = 1'b1;
    if (iss)     set_vec[iss_rn] = 1'b1;
    // A set overrides a clear: a new producer is now in flight.
    pend_nxt = (pend & ~clr_vec) | set_vec;
    set_new  = iss & (~pend[iss_rn] | clr_vec[iss_rn]);
    err_hit  = iss & pend[iss_rn] & ~clr_vec[iss_rn];
    same_clr = clear_x & clear_y & (wnx == wny);
    n_clr    = (AW+1)'(clear_x) + (AW+1)'(clear_y)
             - (AW+1)'(same_clr);
    cnt_nxt  = pend_cnt + (AW+1)'(set_new) - n_clr;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wey && wny == AW'(i))
          rf[i] <= dy;
        else if (wex && wnx == AW'(i))
          rf[i] <= dx;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend     <= '0;
      pend_cnt <= '0;
      sb_err   <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
      if (err_hit) sb_err <= 1'b1;
    end
  end

  assign idle = (pend_cnt == '0);

`ifdef FPU_REGFILE_BYPASS_EN
  always_comb begin
    qa = rf[rna];
    qb = rf[rnb];
    if (wex && wnx == rna) qa = dx;
    if (wey && wny == rna) qa = dy;
    if (wex && wnx == rnb) qb = dx;
    if (wey && wny == rnb) qb = dy;
    busy_a = pend[rna] & ~clr_vec[rna];
    busy_b = pend[rnb] & ~clr_vec[rnb];
  end
`else
  assign qa     = rf[rna];
  assign qb     = rf[rnb];
  assign busy_a = pend[rna];
  assign busy_b = pend[rnb];
`endif

endmodule

// File: tb/tb_fpu_regfile_sb.sv
// Bench for fpu_regfile_sb: array/bit-per-register model checked every cycle,
// plus directed vectors with literal expectations.
module tb_fpu_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          clr;
  logic [AW-1:0] rna, rnb, wnx, wny, iss_rn;
  logic [DW-1:0] qa, qb, dx, dy;
  logic          busy_a, busy_b, wex, wey, iss;
  logic [AW:0]   pend_cnt;
  logic          idle, sb_err;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  logic [DW-1:0] m_reg [NREG];
  bit            m_pend [NREG];
  bit            m_err;
  bit            cx, cy;
  int            cnt;
  logic [DW-1:0] e_qa, e_qb;
  bit            e_ba, e_bb;

  fpu_regfile_sb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .clr(clr),
    .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .busy_a(busy_a), .busy_b(busy_b),
    .wnx(wnx), .wny(wny), .dx(dx), .dy(dy),
    .wex(wex), .wey(wey),
    .iss(iss), .iss_rn(iss_rn),
    .pend_cnt(pend_cnt), .idle(idle), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: registers as an array, scoreboard as one bit per register.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i] = '0;
        m_pend[i] = 0;
      end
      m_err = 0;
    end else begin
      cx = wex && m_pend[wnx];
      cy = wey && m_pend[wny];
      if (wex) m_reg[wnx] = dx;
      if (wey) m_reg[wny] = dy;
      if (cx) m_pend[wnx] = 0;
      if (cy) m_pend[wny] = 0;
      if (iss) begin
        if (m_pend[iss_rn]) m_err = 1;
        m_pend[iss_rn] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      cnt = 0;
      for (int i = 0; i < NREG; i++) cnt += int'(m_pend[i]);
      e_qa = m_reg[rna];
      e_qb = m_reg[rnb];
      e_ba = m_pend[rna];
      e_bb = m_pend[rnb];
`ifdef FPU_REGFILE_BYPASS_EN
      if (wex && wnx == rna) e_qa = dx;
      if (wey && wny == rna) e_qa = dy;
      if (wex && wnx == rnb) e_qb = dx;
      if (wey && wny == rnb) e_qb = dy;
      if ((wex && wnx == rna) || (wey && wny == rna)) e_ba = 0;
      if ((wex && wnx == rnb) || (wey && wny == rnb)) e_bb = 0;
`endif
      chk("m_qa", qa, e_qa);
      chk("m_qb", qb, e_qb);
      chk("m_busy_a", busy_a, e_ba);
      chk("m_busy_b", busy_b, e_bb);
      chk("m_pend_cnt", pend_cnt, cnt);
      chk("m_idle", idle, cnt == 0);
      chk("m_sb_err", sb_err, m_err);
    end
  end

  task automatic nop();
    rna = '0; rnb = '0;
    wnx = '0; wny = '0;
    dx = '0; dy = '0;
    wex = 0; wey = 0;
    iss = 0; iss_rn = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1;
    nop();
    step();
    step();
    run_cmp = 1;
    @(negedge clk);
    chk("rst_qa", qa, 0);
    chk("rst_qb", qb, 0);
    chk("rst_cnt", pend_cnt, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", sb_err, 0);

    step(); clr = 0; nop(); rna = 7;
    @(negedge clk);
    chk("r7_zero", qa, 0);

    step(); nop();
    wex = 1; wey = 1; wnx = 3; wny = 3;
    dx = 32'h11111111; dy = 32'h22222222;
    @(negedge clk);
    step(); nop(); rna = 3;
    @(negedge clk);
    chk("same_reg_y_wins", qa, 32'h22222222);

    step(); nop();
    wex = 1; wnx = 4; dx = 32'hA;
    wey = 1; wny = 5; dy = 32'hB;
    @(negedge clk);
    step(); nop(); rna = 4; rnb = 5;
    @(negedge clk);
    chk("dual_r4", qa, 32'hA);
    chk("dual_r5", qb, 32'hB);

    step(); nop(); iss = 1; iss_rn = 2;
    @(negedge clk);
    step(); nop(); iss = 1; iss_rn = 9; rna = 9;
    @(negedge clk);
    chk("cnt_after_r2", pend_cnt, 1);
    chk("busy_r9_before", busy_a, 0);
    step(); nop();
    wex = 1; wnx = 2; dx = 32'h2222;
    wey = 1; wny = 9; dy = 32'h9999;
    rna = 9;
    @(negedge clk);
    chk("cnt_after_r9", pend_cnt, 2);
`ifdef FPU_REGFILE_BYPASS_EN
    chk("busy_r9_wb", busy_a, 0);
`else
    chk("busy_r9_wb", busy_a, 1);
`endif
    step(); nop();
    @(negedge clk);
    chk("cnt_after_wb", pend_cnt, 0);
    chk("idle_after_wb", idle, 1);

    step(); nop(); iss = 1; iss_rn = 20;
    @(negedge clk);
    step(); nop(); wex = 1; wey = 1; wnx = 20; wny = 20;
    @(negedge clk);
    chk("cnt_r20", pend_cnt, 1);
    step(); nop();
    @(negedge clk);
    chk("cnt_xy_same_clear", pend_cnt, 0);

    for (int i = 0; i < NREG; i++) begin
      step(); nop(); iss = 1; iss_rn = AW'(i);
      @(negedge clk);
    end
    step(); nop(); rna = 31;
    @(negedge clk);
    chk("cnt_full", pend_cnt, 32);
    chk("idle_full", idle, 0);
    chk("busy_r31", busy_a, 1);
    for (int k = 0; k < NREG / 2; k++) begin
      step(); nop();
      wex = 1; wnx = AW'(2 * k); dx = DW'(k);
      wey = 1; wny = AW'(2 * k + 1); dy = DW'(k + 100);
      @(negedge clk);
    end
    step(); nop();
    @(negedge clk);
    chk("cnt_drained", pend_cnt, 0);
    chk("idle_drained", idle, 1);

    step(); nop(); iss = 1; iss_rn = 6;
    @(negedge clk);
    step(); nop(); iss = 1; iss_rn = 6;
    wex = 1; wnx = 6; dx = 32'h55; rna = 6;
    @(negedge clk);
    chk("cnt_r6", pend_cnt, 1);
    step(); nop(); iss = 1; iss_rn = 6; rna = 6;
    @(negedge clk);
    chk("cnt_set_wins", pend_cnt, 1);
    chk("no_err_set_wins", sb_err, 0);
    chk("busy_r6", busy_a, 1);
    step(); nop();
    @(negedge clk);
    chk("err_waw", sb_err, 1);
    chk("cnt_waw", pend_cnt, 1);
    step(); step();
    @(negedge clk);
    chk("err_sticky", sb_err, 1);

    step(); nop(); wex = 1; wnx = 12; dx = 32'h12345678;
    @(negedge clk);
    step(); nop(); iss = 1; iss_rn = 12;
    @(negedge clk);
    step(); nop(); wey = 1; wny = 12; dy = 32'hDEADBEEF; rna = 12;
    @(negedge clk);
`ifdef FPU_REGFILE_BYPASS_EN
    chk("byp_qa", qa, 32'hDEADBEEF);
    chk("byp_busy", busy_a, 0);
`else
    chk("byp_qa", qa, 32'h12345678);
    chk("byp_busy", busy_a, 1);
`endif
    step(); nop(); rna = 12;
    @(negedge clk);
    chk("r12_after", qa, 32'hDEADBEEF);
    chk("r12_busy_after", busy_a, 0);
    chk("cnt_r12_after", pend_cnt, 1);

    step(); nop(); clr = 1; wex = 1; wnx = 1; dx = 32'hFF;
    @(negedge clk);
    chk("clr_err", sb_err, 0);
    chk("clr_cnt", pend_cnt, 0);
    chk("clr_idle", idle, 1);
    step(); clr = 0; nop(); rna = 1; rnb = 6;
    @(negedge clk);
    chk("clr_write_lost", qa, 0);
    chk("clr_r6", qb, 0);

    step();
    run_cmp = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
